// File: rtl/sdram_port_arbiter.sv
`timescale 1ns/1ps
// sdram_port_arbiter
// Shares one SDRAM controller command port between three requesters and
// schedules auto-refresh. Port 0 (video) has fixed top priority, ports 1
// (CPU) and 2 (JTAG bridge) alternate round-robin. Refresh is deferred behind
// traffic while only one refresh is owed, and forced once two are owed.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   req/req_we        per-port request level (held until ack) and write enable
//   req_addr/wdata    packed per-port address and write data, port n at [n*W +: W]
//   ack, rdata        one-cycle completion pulse per port, read data with ack
//   mem_req/we/addr/wdata  latched access towards the SDRAM controller
//   mem_refresh       auto-refresh request level
//   mem_ack/mem_rdata controller completion pulse and read data
//   grant             owning port 0-2, 3 when idle or refreshing
//   refresh_overrun   sticky flag: refresh debt saturated
module sdram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 24,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned REFRESH_INTERVAL = 390
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req,
  input  logic [2:0]              req_we,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_refresh,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              grant,
  output logic                    refresh_overrun
);

  localparam int unsigned CNT_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              debt;
  logic                    rr_last2;     // 1: port 2 was the last of {1,2} granted

  logic                    expire;
  logic                    refresh_done;
  logic                    pick_valid;
  logic                    pick_refresh;
  logic [1:0]              pick_port;
  logic                    pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;

  assign expire       = (cnt == '0);
  assign refresh_done = (state == REFRESH) && mem_ack;

  // IDLE arbitration: forced refresh, port 0, round-robin 1/2, deferred refresh
  always_comb begin
    pick_valid   = 1'b0;
    pick_refresh = 1'b0;
    pick_port    = 2'd0;
    if (debt >= 2'd2) begin
      pick_refresh = 1'b1;
    end else if (req[0]) begin
      pick_valid = 1'b1;
      pick_port  = 2'd0;
    end else if (req[1] && req[2]) begin
      pick_valid = 1'b1;
      pick_port  = rr_last2 ? 2'd1 : 2'd2;
    end else if (req[1]) begin
      pick_valid = 1'b1;
      pick_port  = 2'd1;
    end else if (req[2]) begin
      pick_valid = 1'b1;
      pick_port  = 2'd2;
    end else if (debt != 2'd0) begin
      pick_refresh = 1'b1;
    end
  end

  // Select the chosen port's request fields
  always_comb begin
    pick_we    = req_we[0];
    pick_addr  = req_addr[0 +: ADDR_WIDTH];
    pick_wdata = req_wdata[0 +: DATA_WIDTH];
    case (pick_port)
      2'd1: begin
        pick_we    = req_we[1];
        pick_addr  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[DATA_WIDTH +: DATA_WIDTH];
      end
      2'd2: begin
        pick_we    = req_we[2];
        pick_addr  = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        pick_wdata = req_wdata[2*DATA_WIDTH +: DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // Refresh interval counter and owed-refresh debt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= CNT_RELOAD;
      debt            <= 2'd0;
      refresh_overrun <= 1'b0;
    end else begin
      cnt <= expire ? CNT_RELOAD : cnt - CNT_W'(1);
      // expiry and completion in the same cycle cancel out
      if (expire && !refresh_done) begin
        if (debt == 2'd3) refresh_overrun <= 1'b1;
        else              debt <= debt + 2'd1;
      end else if (refresh_done && !expire) begin
        debt <= debt - 2'd1;
      end
    end
  end

  // Access / refresh sequencer with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'd3;
      ack         <= 3'b000;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_refresh <= 1'b0;
      rr_last2    <= 1'b1;
    end else begin
      ack <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_refresh) begin
            state       <= REFRESH;
            mem_refresh <= 1'b1;
          end else if (pick_valid) begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= pick_we;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            grant     <= pick_port;
            if (pick_port != 2'd0) rr_last2 <= (pick_port == 2'd2);
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_rdata;
            ack     <= 3'b001 << grant;
            state   <= DONE;
          end
        end
        REFRESH: begin
          if (mem_ack) begin
            mem_refresh <= 1'b0;
            state       <= IDLE;
          end
        end
        DONE: begin
          // one quiet cycle so the requester can drop req before re-arbitration
          grant <= 2'd3;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
// tb_sdram_port_arbiter
// Directed scoreboard bench: requester driver, SDRAM controller model,
// ack monitor, all decoupled through expected-transaction queues.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned RI = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        req, req_we, ack;
  logic [3*AW-1:0]   req_addr;
  logic [3*DW-1:0]   req_wdata;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic              mem_req, mem_we, mem_refresh, mem_ack, refresh_overrun;
  logic [AW-1:0]     mem_addr;
  logic [1:0]        grant;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_refresh(mem_refresh), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant(grant), .refresh_overrun(refresh_overrun));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [1:0]    port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t pq0[$], pq1[$], pq2[$];
  txn_t ack_q[$], mem_q[$];
  int   total = 0;
  int   bad = 0;
  int   lat = 1;
  bit   hold_access = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic issue(input logic [1:0] p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    txn_t t;
    t = '{port: p, we: we, addr: a, wdata: wd, rdata: rd};
    case (p)
      2'd0:    pq0.push_back(t);
      2'd1:    pq1.push_back(t);
      default: pq2.push_back(t);
    endcase
    ack_q.push_back(t);
    mem_q.push_back(t);
  endtask

  function automatic bit peek(input int p, output txn_t t);
    t = '0;
    case (p)
      0: if (pq0.size() != 0) begin t = pq0[0]; return 1'b1; end
      1: if (pq1.size() != 0) begin t = pq1[0]; return 1'b1; end
      default: if (pq2.size() != 0) begin t = pq2[0]; return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  function automatic void pop_port(input int p);
    case (p)
      0: if (pq0.size() != 0) void'(pq0.pop_front());
      1: if (pq1.size() != 0) void'(pq1.pop_front());
      default: if (pq2.size() != 0) void'(pq2.pop_front());
    endcase
  endfunction

  // Requesters: hold req until ack, scramble fields once the access is in flight
  initial begin
    txn_t t;
    bit   has;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        if (ack[p]) pop_port(p);
        has = peek(p, t);
        req[p] = has;
        if (has && mem_req && grant == 2'(p)) begin
          req_we[p] = ~t.we;
          req_addr[p*AW +: AW] = ~t.addr;
          req_wdata[p*DW +: DW] = ~t.wdata;
        end else begin
          req_we[p] = t.we;
          req_addr[p*AW +: AW] = t.addr;
          req_wdata[p*DW +: DW] = t.wdata;
        end
      end
    end
  end

  // SDRAM controller model: ack after lat cycles, rdata = addr[15:0] + 0xBDCC
  initial begin
    int   busy;
    txn_t t;
    busy = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      chk("req_refresh_exclusive", 32'(mem_req & mem_refresh), 32'd0);
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy = 0;
      end else if (mem_req || mem_refresh) begin
        busy++;
        if (busy >= lat && !(mem_req && hold_access)) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr[15:0] + 16'hBDCC;
          busy = 0;
          if (mem_req) begin
            if (mem_q.size() == 0) begin
              total++; bad++;
              $display("FAIL stray_mem_req: got addr %0h want no access", mem_addr);
            end else begin
              t = mem_q.pop_front();
              chk("mem_addr", 32'(mem_addr), 32'(t.addr));
              chk("mem_we", 32'(mem_we), 32'(t.we));
              chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
            end
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Ack monitor
  initial begin
    txn_t t;
    logic [2:0] exp_ack;
    forever begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL stray_ack: got %b want 000", ack);
        end else begin
          t = ack_q.pop_front();
          exp_ack = 3'b001 << t.port;
          chk("ack_port", 32'(ack), 32'(exp_ack));
          chk("rdata", 32'(rdata), 32'(t.rdata));
          chk("grant_at_ack", 32'(grant), 32'(t.port));
        end
      end
    end
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (ack_q.size() != 0 || mem_q.size() != 0); i++) @(negedge clk);
    chk("drain_ack_q", 32'(ack_q.size()), 32'd0);
    chk("drain_mem_q", 32'(mem_q.size()), 32'd0);
  endtask

  task automatic wait_rise(input int budget, output int t);
    logic prev;
    prev = mem_refresh;
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_refresh && !prev) begin
        t = cyc;
        break;
      end
      prev = mem_refresh;
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL refresh_timeout: got no rise want one within %0d cycles", budget);
    end
  endtask

  initial begin
    int r[5];
    int t0;
    int tr;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_refresh", 32'(mem_refresh), 32'd0);
    chk("rst_overrun", 32'(refresh_overrun), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;

    // single read on port 1, slow controller
    lat = 3;
    issue(2'd1, 1'b0, 24'h000123, 16'h0000, 16'hBEEF);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = ack[1];
    end
    chk("t1_ack_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t1_ack_one_cycle", 32'(ack), 32'd0);
    chk("t1_grant_back", 32'(grant), 32'd3);
    drain(20);

    // all three request: port 0 first, then 1/2 alternate starting with 2
    lat = 1;
    issue(2'd0, 1'b1, 24'h100000, 16'h1111, 16'hBDCC);
    issue(2'd0, 1'b0, 24'h100010, 16'h0000, 16'hBDDC);
    issue(2'd0, 1'b1, 24'h100020, 16'h2222, 16'hBDEC);
    issue(2'd2, 1'b0, 24'h200001, 16'h0000, 16'hBDCD);
    issue(2'd1, 1'b1, 24'h000002, 16'h3333, 16'hBDCE);
    issue(2'd2, 1'b1, 24'h200003, 16'h4444, 16'hBDCF);
    issue(2'd1, 1'b0, 24'h000004, 16'h0000, 16'hBDD0);
    issue(2'd2, 1'b0, 24'h200005, 16'h0000, 16'hBDD1);
    issue(2'd1, 1'b0, 24'h000006, 16'h0000, 16'hBDD2);
    drain(200);

    // idle: one refresh per interval, never overrun
    repeat (24) @(negedge clk);
    for (int i = 0; i < 5; i++) wait_rise(30, r[i]);
    for (int i = 1; i < 5; i++) chk("idle_refresh_period", 32'(r[i] - r[i-1]), 32'd8);
    chk("idle_overrun", 32'(refresh_overrun), 32'd0);

    // port 0 saturating from reset: first refresh forced only after second expiry
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) issue(2'd0, 1'b0, 24'h300000 + 24'(i), 16'h0000, 16'hBDCC + 16'(i));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    wait_rise(40, tr);
    chk("sat_first_refresh_edge", 32'(tr - t0), 32'd19);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    chk("sat_grant_after_refresh", 32'(grant), 32'd0);
    drain(200);
    chk("sat_overrun", 32'(refresh_overrun), 32'd0);

    // withheld access ack: debt saturates, overrun sticks
    hold_access = 1'b1;
    issue(2'd1, 1'b0, 24'h000777, 16'h0000, 16'hC543);
    repeat (44) @(negedge clk);
    chk("overrun_set", 32'(refresh_overrun), 32'd1);
    hold_access = 1'b0;
    drain(40);
    repeat (40) @(negedge clk);
    chk("overrun_sticky", 32'(refresh_overrun), 32'd1);

    // reset mid-access: outputs clear asynchronously, no stale ack afterwards
    hold_access = 1'b1;
    issue(2'd1, 1'b0, 24'h000888, 16'h0000, 16'hC654);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req && (grant == 2'd1);
    end
    chk("rst_mid_access_started", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_ack", 32'(ack), 32'd0);
    chk("async_mem_refresh", 32'(mem_refresh), 32'd0);
    chk("async_grant", 32'(grant), 32'd3);
    chk("async_overrun", 32'(refresh_overrun), 32'd0);
    pq0.delete(); pq1.delete(); pq2.delete();
    ack_q.delete(); mem_q.delete();
    hold_access = 1'b0;
    issue(2'd2, 1'b1, 24'h2000AA, 16'h5555, 16'hBE76);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drain(60);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one SDRAM controller command port between three requesters: port 0 video fetch (highest priority), port 1 CPU, port 2 JTAG debug bridge.
- Ports 1 and 2 are served round-robin.
- Also schedules auto-refresh: refresh is deferred behind traffic until debt builds up, then forced.
- Sits between the demo core and the SDRAM controller in jtagdemo_top, replacing the tied-off SDRAM defaults; runs on sysclk.

Parameters:
ADDR_WIDTH, 24, word address width per requester
DATA_WIDTH, 16, data width
REFRESH_INTERVAL, 390, clk cycles between refresh due events (7.8 us at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
req  input  3  per-port request level; held until matching ack
req_we  input  3  per-port write enable (1 = write)
req_addr  input  3*ADDR_WIDTH  packed addresses, port n at [n*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  3*DATA_WIDTH  packed write data, same packing
ack  output  3  one-cycle completion pulse per port
rdata  output  DATA_WIDTH  read data, valid while any ack bit = 1
mem_req  output  1  access request to SDRAM controller (level)
mem_we  output  1  write enable for current access
mem_addr  output  ADDR_WIDTH  latched address
mem_wdata  output  DATA_WIDTH  latched write data
mem_refresh  output  1  auto-refresh request (level)
mem_ack  input  1  controller completion, single-cycle pulse per mem_req or mem_refresh
mem_rdata  input  DATA_WIDTH  controller read data, valid with mem_ack
grant  output  2  port currently owning the memory (0-2), 3 = none or refresh
refresh_overrun  output  1  sticky: refresh debt saturated

Behaviour:
- Reset: all outputs 0 except grant = 3; state IDLE; refresh counter = REFRESH_INTERVAL-1; debt = 0; round-robin pointer favours port 1. Reset mid-access abandons the access silently (no ack).
- States: IDLE, ACCESS, REFRESH, DONE.
- Refresh counter: decrements every cycle; at 0 it reloads REFRESH_INTERVAL-1 and debt increments.
- Debt is 2-bit and saturates at 3; an expiry at 3 sets refresh_overrun, which is cleared only by reset.
- Debt decrements when a refresh completes (mem_ack in REFRESH). Expiry and completion in the same cycle leave debt unchanged.
- IDLE arbitration, first match wins:
  - debt >= 2 → REFRESH
  - req[0] → port 0
  - req[1] or req[2] → round-robin: prefer the port not granted last among {1,2}; with only one requesting, grant it
  - debt >= 1 → REFRESH
  - otherwise stay IDLE
- Grant to port n: on the next edge go to ACCESS; latch req_we[n], addr, wdata into mem_*; mem_req = 1; grant = n; if n is 1 or 2, update the rr pointer.
- ACCESS: hold mem_req and latched fields until mem_ack. On mem_ack: mem_req = 0, rdata <= mem_rdata (reads and writes alike), ack[n] = 1, go to DONE.
- DONE: lasts one cycle with ack[n] high and no arbitration, so the requester can drop req. Then go to IDLE with grant = 3 and ack = 0.
- REFRESH: mem_refresh = 1 and grant = 3 until mem_ack. Then mem_refresh = 0, debt decrements, go to IDLE. No ack pulse.
- mem_req and mem_refresh are never both 1.
- Latency: req sampled high in IDLE at cycle 0 → mem_req = 1 at cycle 1. mem_ack at cycle k → ack = 1 at cycle k+1 → IDLE arbitrates again at cycle k+2.
- mem_ack in IDLE or DONE is ignored.
- Changes to req_addr, req_we or req_wdata after grant have no effect on the access in flight.

Test Plan:
- Single read on port 1 (addr 0x000123), mem_ack with mem_rdata 0xBEEF 3 cycles after mem_req → mem_addr = 0x000123, mem_we = 0; ack = 3'b010 for exactly one cycle with rdata = 0xBEEF; grant returns to 3.
- Ports 0, 1 and 2 all request continuously, each served with immediate ack → grant order 0,0,0…; drop port 0 → grants alternate 1,2,1,2; ack never goes to a non-requesting port.
- REFRESH_INTERVAL = 8, no requests → mem_refresh asserted about 2 cycles after each expiry; debt never exceeds 1; refresh_overrun stays 0.
- REFRESH_INTERVAL = 8, port 0 saturating traffic → after the second expiry, refresh wins the next IDLE ahead of port 0; port 0 is then granted after the refresh mem_ack.
- REFRESH_INTERVAL = 8, mem_ack withheld for 40 cycles during an access → debt reaches 3 and refresh_overrun = 1 (sticky through later refreshes); reset clears it.
- Assert reset during ACCESS with mem_req = 1 → mem_req, ack and mem_refresh are 0 immediately (asynchronous); grant = 3; after release, normal arbitration resumes with no stale ack.
